// File: rtl/ring_rr_arbiter_pkg.sv
// ring_arb_pkg: state encoding and token helpers shared by the ring arbiter.
// The optional hold timeout is selected with RING_ARB_TIMEOUT_EN.
package ring_arb_pkg;

  // Widest requester vector the helpers handle.
  localparam int MAX_REQ = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01
  } state_e;

  // Binary index of a one-hot vector (0 when empty).
  function automatic logic [4:0] oh2idx(input logic [MAX_REQ-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (v[i]) r = r | 5'(i);
    return r;
  endfunction

  // Rotate an n-bit one-hot toward the LSB; bit 0 wraps to bit n-1.
  function automatic logic [MAX_REQ-1:0] rotr1(input logic [MAX_REQ-1:0] v, input int n);
    return (v >> 1) | (MAX_REQ'(v[0]) << (n - 1));
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Requester-side bus of the ring arbiter: requests/release in, grant status out.
// The optional hold timeout is selected with RING_ARB_TIMEOUT_EN.
interface ring_rr_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3,
  parameter int HOLD_W  = 4
);
  logic               i_enable_n;
  logic [NUM_REQ-1:0] i_req;
  logic               i_release;
  logic [NUM_REQ-1:0] o_grant;
  logic               o_grant_valid;
  logic [IDX_W-1:0]   o_owner_idx;
  logic [NUM_REQ-1:0] o_token;
  logic [HOLD_W-1:0]  o_hold_cnt;
  logic               o_preempt;

  modport master (
    output i_enable_n, i_req, i_release,
    input  o_grant, o_grant_valid, o_owner_idx, o_token, o_hold_cnt, o_preempt
  );

  modport slave (
    input  i_enable_n, i_req, i_release,
    output o_grant, o_grant_valid, o_owner_idx, o_token, o_hold_cnt, o_preempt
  );
endinterface

// File: rtl/ring_rr_arbiter_pick.sv
// ring_priority_pick: combinational round-robin pick. Scan starts at the token
// bit and walks toward the LSB, wrapping to the MSB; first set request wins.
// The optional hold timeout of the arbiter is selected with RING_ARB_TIMEOUT_EN.
module ring_priority_pick #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] token_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               vld_o
);

  // Priority scan from the token position downward with wrap.
  always_comb begin
    int tidx;
    logic [IDX_W-1:0] sel;
    win_o = '0;
    vld_o = 1'b0;
    tidx  = 0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (token_i[i]) tidx = i;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'((tidx - k + NUM_REQ) % NUM_REQ);
      if (!vld_o && req_i[sel]) begin
        win_o[sel] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: one-hot token round-robin arbiter with grant/hold/release
// sequencing and a hold counter. A forced release after MAX_HOLD cycles of
// contention is compiled in with RING_ARB_TIMEOUT_EN.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4,
  parameter int IDX_W    = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  ring_rr_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("ring_rr_arbiter: NUM_REQ out of range");
  end
  if ((1 << HOLD_W) <= MAX_HOLD) begin : g_bad_hold_w
    $error("ring_rr_arbiter: HOLD_W too narrow for MAX_HOLD");
  end
  if (IDX_W != $clog2(NUM_REQ)) begin : g_bad_idx_w
    $error("ring_rr_arbiter: IDX_W must be clog2(NUM_REQ)");
  end

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q, token_q, token_d, win;
  logic [IDX_W-1:0]   owner_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               preempt_q, win_vld, rel, tmo;

  ring_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .token_i (token_q),
    .req_i   (bus.i_req),
    .win_o   (win),
    .vld_o   (win_vld)
  );

  // Release/timeout detection and next token for the current owner.
  always_comb begin
    rel = bus.i_release | ~(|(bus.i_req & grant_q));
`ifdef RING_ARB_TIMEOUT_EN
    tmo = (hold_q == HOLD_W'(MAX_HOLD - 1)) && (|(bus.i_req & ~grant_q));
`else
    tmo = 1'b0;
`endif
    token_d = NUM_REQ'(rotr1(MAX_REQ'(grant_q), NUM_REQ));
  end

  // Grant FSM with registered outputs; release always passes through IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      token_q   <= {1'b1, {(NUM_REQ-1){1'b0}}};
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!bus.i_enable_n && win_vld) begin
            state_q <= ST_GRANT;
            grant_q <= win;
            owner_q <= IDX_W'(oh2idx(MAX_REQ'(win)));
            hold_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (rel || tmo) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            token_q   <= token_d;
            // A voluntary release on the timeout cycle is not a preemption.
            preempt_q <= tmo & ~rel;
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          owner_q <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_grant_valid = (state_q == ST_GRANT);
  assign bus.o_owner_idx   = owner_q;
  assign bus.o_token       = token_q;
  assign bus.o_hold_cnt    = hold_q;
  assign bus.o_preempt     = preempt_q;

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_REQ requesters.
- Uses a one-hot ring-counter token as its rotating priority pointer. The token moves MSB→LSB and resets to MSB=1, the same as the team's ring counters.
- Sequences grant, hold and release, and tracks how long the current owner has held the grant with a hold counter.
- Sits between requesting datapath blocks, such as counter/loader units, and a single shared load/count resource.

Parameters:
- NUM_REQ, 8, number of requesters; must be 2 or more.
- MAX_HOLD, 4, maximum grant length in cycles when the timeout feature is compiled in.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.
- IDX_W, 3, width of the owner index, equal to $clog2(NUM_REQ).

Ports:
- i_clk, input, 1, clock. All state changes on the posedge.
- i_reset_n, input, 1, synchronous, active-low reset.
- i_enable_n, input, 1, active-low arbitration enable.
- i_req, input, NUM_REQ, request vector; bit k is requester k.
- i_release, input, 1, single-cycle pulse from the current owner to give up the grant.
- o_grant, output, NUM_REQ, one-hot grant; all zeros when idle.
- o_grant_valid, output, 1, high while any grant is active.
- o_owner_idx, output, IDX_W, binary index of the current owner; 0 when idle.
- o_token, output, NUM_REQ, one-hot priority pointer.
- o_hold_cnt, output, HOLD_W, cycles elapsed in the current grant.
- o_preempt, output, 1, one-cycle pulse on a forced release (timeout build only).

Behaviour:
- Clock and reset: clock i_clk; reset i_reset_n, synchronous, active-low.
- Reset values: o_grant=0, o_grant_valid=0, o_owner_idx=0, o_token={1,0...0} (MSB set), o_hold_cnt=0, o_preempt=0, state=IDLE.
- Reset mid-grant: the grant drops at the same clock edge; it is not finished first.
- Priority pick (combinational): scan starts at the token bit and moves toward the LSB, wrapping from bit 0 to bit NUM_REQ-1. The first set i_req bit wins.
- State IDLE:
  - If i_enable_n=0 and |i_req, go to GRANT at the next edge.
  - On that edge: o_grant = winner one-hot, o_grant_valid=1, o_owner_idx = winner, o_hold_cnt=0.
  - Latency from request to grant is 1 cycle.
- State GRANT:
  - o_hold_cnt increments every cycle and saturates at all-ones.
  - Non-owner request bits are ignored.
- Release conditions: i_release=1, or i_req[owner]=0. On release, at the next edge:
  - o_grant=0, o_grant_valid=0, o_hold_cnt=0, state=IDLE.
  - o_token = owner one-hot rotated one position toward the LSB; owner bit 0 wraps to the MSB.
- Mandatory bubble: there is always 1 idle cycle between consecutive grants. Back-to-back grant spacing is therefore hold + 2 cycles.
- Enable deasserted during GRANT: the current grant continues until release. No new grant is issued while i_enable_n=1.
- o_token does not change except on a release.
- Simultaneous i_release and owner request drop: treated as a single release.
- i_release while IDLE: ignored.
- Single requester: that requester gets every grant. The token still rotates after each grant, but priority is irrelevant.
- States are encoded as 2 bits (IDLE=00, GRANT=01); the other codes recover to IDLE.

Optional Feature:
- Macro: RING_ARB_TIMEOUT_EN.
- Defined:
  - If o_hold_cnt == MAX_HOLD-1 and another requester is asserting i_req, the grant is forced off at the next edge.
  - o_preempt pulses for that one cycle, and the token rotates exactly as for a normal release.
  - With no other requester, the owner keeps the grant beyond MAX_HOLD.
- Undefined: there is no timeout, o_preempt is tied to 0, and the owner holds the grant until release.

Decomposition:
- Package ring_arb_pkg holds:
  - the state encoding constants ST_IDLE and ST_GRANT;
  - a one-hot-to-index function;
  - a rotate-right-by-1 function for the token.
- Sub-module ring_priority_pick is combinational. Inputs are token and req; outputs are the one-hot winner and a valid flag. It is unit-tested separately.

Test Plan (NUM_REQ=8, MAX_HOLD=4):
1. Hold i_reset_n=0 for 2 cycles, then release → o_token=8'h80, o_grant=0, o_grant_valid=0. Reset asserted while requester 2 holds the grant → o_grant=0 at the next edge.
2. i_req=8'h81 from IDLE:
   - → grant 8'h80 one cycle later.
   - Pulse i_release → grant drops and o_token=8'h40.
   - After the bubble cycle, o_grant=8'h01.
3. i_req=8'hFF held constant, each owner releasing after 1 cycle → grant order 7,6,5,...,0,7. Each grant is 1 cycle with a 1-cycle bubble between grants.
4. With i_enable_n=1 and i_req=8'h10 → no grant. Set i_enable_n=0 → o_grant=8'h10 next cycle. Set i_enable_n=1 during the grant → the grant persists until requester 4 drops i_req.
5. Timeout build, i_req=8'h0C held:
   - → owner 3 granted.
   - At o_hold_cnt=3, o_preempt=1 and the grant drops; o_token=8'h04.
   - Then owner 2 is granted.
   - Non-timeout build, same stimulus → owner 3 holds and o_hold_cnt saturates at 15.
6. i_release and i_req[owner] drop in the same cycle → exactly one release, one token rotation, and o_preempt stays 0.
